aes_round_key_gen: RTL and testbench
====================================

// Module: aes_round_key_gen
// PURPOSE
//  Iterative AES-128 key schedule: expands a 128-bit cipher key into round keys 0..NR, one per handshake.
//  Sits beside the round datapath and feeds AddRoundKey, which consumes the MixColumns output each round.
//  Byte order matches the datapath: bits [127:120] = byte 0 (row 0, col 0); word w0 = bits [127:96].
// PARAMETERS
//  NR  10  last round-key index emitted. 10 = AES-128; 1..9 allowed only for reduced-round test builds.
// PORTS
//  clk       input   1    rising-edge clock, the only clock
//  rst_n     input   1    synchronous active-low reset, sampled on rising edge of clk
//  start     input   1    single-cycle request to begin expansion of key_in (ignored unless idle)
//  key_in    input   128  cipher key, sampled on the accepted start cycle only
//  rk_valid  output  1    rk_out/rk_idx hold a valid round key
//  rk_ready  input   1    consumer accepts the round key when rk_valid && rk_ready
//  rk_out    output  128  current round key
//  rk_idx    output  4    round index of rk_out, 0..NR
//  busy      output  1    high from accepted start until round key NR is accepted
//  done      output  1    one-cycle pulse on the cycle after round key NR is accepted
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): state=IDLE, rk_valid=0, busy=0, done=0, rk_out=0, rk_idx=0, rcon=8'h01.
//   Reset applies mid-expansion: all progress is abandoned and no done pulse is produced.
//  States: IDLE, RUN.
//  IDLE: start=1 -> next edge: rk_out<=key_in, rk_idx<=0, rcon<=8'h01, rk_valid<=1, busy<=1, go to RUN.
//   Latency start -> first rk_valid = 1 cycle.
//  RUN, rk_valid && !rk_ready: stall; rk_out, rk_idx, rcon, rk_valid hold unchanged indefinitely.
//  RUN, handshake with rk_idx<NR: next edge: rk_out<=next_key(rk_out,rcon), rk_idx<=rk_idx+1,
//   rcon<=xtime(rcon) (x2 in GF(2^8), reduce with 8'h1b when bit 7 set). rk_valid stays 1, giving
//   one round key per cycle under continuous rk_ready.
//  RUN, handshake with rk_idx==NR: next edge: rk_valid<=0, busy<=0, done<=1 (one cycle only), go to IDLE.
//   rk_out/rk_idx keep the final key value; they are don't-care while rk_valid=0.
//  next_key: w0..w3 = rk_out words; t = SubWord(RotWord(w3)) ^ {rcon,24'h0};
//   n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2. RotWord({a,b,c,d})={b,c,d,a}.
//   SubWord = four instances of the team's single-byte S-box module; purely combinational on rk_out.
//  start while busy (including the done cycle's preceding handshake cycle): ignored, no restart.
//  start on the same cycle done=1: accepted (state is IDLE), new run begins normally.
//  rcon sequence for indices 1..10: 01,02,04,08,10,20,40,80,1b,36.
//  No combinational path from rk_ready or start to any output; all outputs are registered.
// TESTING
//  1 Reset: hold rst_n=0 two cycles with start=1 -> rk_valid=0, busy=0, done=0, rk_out=0, rk_idx=0.
//  2 FIPS-197 A.1, rk_ready=1: key 2b7e151628aed2a6abf7158809cf4f3c -> idx0 = key,
//    idx1 = a0fafe1788542cb123a339392a6c7605, idx10 = d014f9a8c9ee2589e13f0cc8b6630ca6 on 11
//    consecutive cycles; done pulses once, the cycle after idx10 is accepted.
//  3 Zero key -> idx1 = 62636363626363636263636362636363; 11 handshakes total; busy high throughout.
//  4 Backpressure: random rk_ready (~50%) with the A.1 key -> identical idx0..10 sequence, every
//    value held stable while stalled, no index skipped or repeated.
//  5 start pulsed at idx 4 of a run with a different key_in -> ignored; run completes with the original keys.
//  6 rst_n=0 for one cycle at idx 6 -> rk_valid=0, no done; subsequent start yields the full fresh sequence.

Source files
------------

// File: rtl/aes_round_key_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : aes_sbox / aes_round_key_gen                                    |
// | Brief    : Single-byte AES S-box and iterative AES-128 round-key generator |
// |            emitting round keys 0..NR over a valid/ready handshake.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Index 0 is the leftmost byte of the concatenation.
    localparam logic [0:255][7:0] c_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign o_byte = c_SBOX[i_byte];

endmodule

module aes_round_key_gen #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         busy,
    output logic         done
);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_RUN  = 1'b1;
    localparam logic [3:0] c_LAST = 4'(NR);

    logic [0:0]   r_state;
    logic [127:0] r_rk_out;
    logic [3:0]   r_rk_idx;
    logic [7:0]   r_rcon;
    logic         r_rk_valid;
    logic         r_busy;
    logic         r_done;

    logic         w_hs;
    logic [31:0]  w_w0;
    logic [31:0]  w_w1;
    logic [31:0]  w_w2;
    logic [31:0]  w_w3;
    logic [31:0]  w_rot;
    logic [31:0]  w_sub;
    logic [31:0]  w_t;
    logic [31:0]  w_n0;
    logic [31:0]  w_n1;
    logic [31:0]  w_n2;
    logic [31:0]  w_n3;
    logic [7:0]   w_rcon_next;

    assign w_hs = r_rk_valid & rk_ready;

    assign w_w0  = r_rk_out[127:96];
    assign w_w1  = r_rk_out[95:64];
    assign w_w2  = r_rk_out[63:32];
    assign w_w3  = r_rk_out[31:0];
    assign w_rot = {w_w3[23:0], w_w3[31:24]};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .i_byte (w_rot[8*gi +: 8]),
                .o_byte (w_sub[8*gi +: 8])
            );
        end
    endgenerate

    assign w_t  = w_sub ^ {r_rcon, 24'h000000};
    assign w_n0 = w_w0 ^ w_t;
    assign w_n1 = w_w1 ^ w_n0;
    assign w_n2 = w_w2 ^ w_n1;
    assign w_n3 = w_w3 ^ w_n2;

    // Multiply by x in GF(2^8), reducing by the AES polynomial.
    assign w_rcon_next = {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= c_IDLE;
            r_rk_out   <= '0;
            r_rk_idx   <= '0;
            r_rcon     <= 8'h01;
            r_rk_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_rk_out   <= key_in;
                        r_rk_idx   <= '0;
                        r_rcon     <= 8'h01;
                        r_rk_valid <= 1'b1;
                        r_busy     <= 1'b1;
                        r_state    <= c_RUN;
                    end
                end
                c_RUN: begin
                    // Without a handshake everything holds, which is the stall.
                    if (w_hs) begin
                        if (r_rk_idx == c_LAST) begin
                            r_rk_valid <= 1'b0;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_state    <= c_IDLE;
                        end else begin
                            r_rk_out <= {w_n0, w_n1, w_n2, w_n3};
                            r_rk_idx <= r_rk_idx + 4'd1;
                            r_rcon   <= w_rcon_next;
                        end
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign rk_valid = r_rk_valid;
    assign rk_out   = r_rk_out;
    assign rk_idx   = r_rk_idx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_aes_round_key_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_aes_round_key_gen                                            |
// | Brief    : Self-checking bench for the AES-128 round-key generator.        |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+

module tb_aes_round_key_gen;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;

    logic [7:0]   ref_sbox [0:255];
    logic [127:0] exp_rk   [0:NR];
    logic [127:0] got      [0:NR];

    aes_round_key_gen #(.NR(NR)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_out   (rk_out),
        .rk_idx   (rk_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference arithmetic: GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse (a^254) then the affine map.
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h01;
            logic [7:0] b;
            for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(a));
            b = (a == 0) ? 8'h00 : inv;
            ref_sbox[a] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
        end
    endtask

    // Word-oriented FIPS-197 key expansion.
    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:4*(NR+1)-1];
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 4*(NR+1); i++) begin
            logic [31:0] t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= NR; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One expansion; checks every presented key against the model. Ends on the done cycle
    // (or right after a mid-run reset).
    task automatic run(input logic [127:0] key, input int ready_pct, input int inject_at,
                       input int reset_at, input bit start_now);
        int  expect_idx = 0;
        int  cycles = 0;
        bit  finished = 0;
        bit  hs;
        expand(key);
        if (!start_now) begin
            @(negedge clk);
            chk("done_one_cycle", {127'b0, done}, 128'd0);
        end
        start    = 1'b1;
        key_in   = key;
        rk_ready = 1'b0;
        @(negedge clk);
        start  = 1'b0;
        key_in = {$urandom, $urandom, $urandom, $urandom};
        chk("start_latency_valid", {127'b0, rk_valid}, 128'd1);
        while (!finished) begin
            if (cycles++ > 400) begin
                chk("run_timeout", 128'd1, 128'd0);
                return;
            end
            if (reset_at == expect_idx) begin
                rst_n    = 1'b0;
                rk_ready = 1'b1;
                @(negedge clk);
                rst_n    = 1'b1;
                rk_ready = 1'b0;
                chk("midreset_valid", {127'b0, rk_valid}, 128'd0);
                chk("midreset_busy", {127'b0, busy}, 128'd0);
                chk("midreset_out", {124'b0, rk_idx}, 128'd0);
                @(negedge clk);
                chk("midreset_no_done", {127'b0, done}, 128'd0);
                chk("midreset_idle", {127'b0, rk_valid}, 128'd0);
                return;
            end
            chk("run_busy", {127'b0, busy}, 128'd1);
            chk("run_valid", {127'b0, rk_valid}, 128'd1);
            chk("run_idx", {124'b0, rk_idx}, 128'(expect_idx));
            chk($sformatf("rk[%0d]", expect_idx), rk_out, exp_rk[expect_idx]);
            if (inject_at == expect_idx) begin
                start  = 1'b1;
                key_in = ~key;
            end
            hs = ($urandom_range(99) < 32'(ready_pct));
            rk_ready = hs;
            if (hs) got[expect_idx] = rk_out;
            @(negedge clk);
            start    = 1'b0;
            rk_ready = 1'b0;
            if (hs) begin
                if (expect_idx == NR) finished = 1;
                else expect_idx++;
            end
        end
        chk("done_pulse", {127'b0, done}, 128'd1);
        chk("done_busy_low", {127'b0, busy}, 128'd0);
        chk("done_valid_low", {127'b0, rk_valid}, 128'd0);
    endtask

    typedef struct {
        logic [127:0] key;
        int           idx;
        logic [127:0] rk;
    } vec_t;

    localparam logic [127:0] c_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    vec_t vecs [0:5];

    initial begin
        vecs[0] = '{c_A1,   0, c_A1};
        vecs[1] = '{c_A1,   1, 128'ha0fafe1788542cb123a339392a6c7605};
        vecs[2] = '{c_A1,   2, 128'hf2c295f27a96b9435935807a7359f67f};
        vecs[3] = '{c_A1,  10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[4] = '{128'd0, 1, 128'h62636363626363636263636362636363};
        vecs[5] = '{128'd0, 2, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa};

        build_sbox();

        rst_n    = 1'b0;
        start    = 1'b1;
        key_in   = c_A1;
        rk_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_valid", {127'b0, rk_valid}, 128'd0);
        chk("reset_busy", {127'b0, busy}, 128'd0);
        chk("reset_done", {127'b0, done}, 128'd0);
        chk("reset_out", rk_out, 128'd0);
        chk("reset_idx", {124'b0, rk_idx}, 128'd0);
        start    = 1'b0;
        rk_ready = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {127'b0, rk_valid}, 128'd0);

        // Known-answer vectors with continuous ready.
        for (int v = 0; v < 6; v++) begin
            run(vecs[v].key, 100, -1, -1, 0);
            chk($sformatf("vec%0d_idx%0d", v, vecs[v].idx), got[vecs[v].idx], vecs[v].rk);
        end

        // Backpressure with the A.1 key and random keys.
        run(c_A1, 50, -1, -1, 0);
        chk("bp_a1_last", got[NR], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        for (int n = 0; n < 4; n++) run({$urandom, $urandom, $urandom, $urandom}, 50, -1, -1, 0);

        // Start while busy is ignored.
        run(c_A1, 100, 4, -1, 0);
        chk("inject_last", got[NR], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Mid-run reset, then a fresh full run.
        run(c_A1, 60, -1, 6, 0);
        run(c_A1, 100, -1, -1, 0);
        chk("after_reset_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);

        // Start on the done cycle is accepted.
        run(128'd0, 100, -1, -1, 0);
        run({$urandom, $urandom, $urandom, $urandom}, 70, -1, -1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
